// File: rtl/msg_uplink_tx_pkg.sv
// Shared types and defaults for the slave-channel uplink transmitter.
package msg_uplink_tx_pkg;

    localparam int         N_CH_DEFAULT      = 5;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hAA;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        HDR_SYNC,
        HDR_CH,
        HDR_LEN,
        PL_LOAD,
        PL_SEND,
        CSUM
    } state_t;

    // Channel index width; a single-channel build still carries a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/msg_uplink_tx_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping at N_CH.
module msg_uplink_tx_rr_arbiter
    import msg_uplink_tx_pkg::*;
#(
    parameter int N_CH = N_CH_DEFAULT,
    localparam int IW  = idx_w(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [N_CH-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    always_comb begin
        int c;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = 0;
        for (int k = 0; k < N_CH; k++) begin
            c = (int'(ptr) + k) % N_CH;
            if (!any && req[c]) begin
                any    = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/msg_uplink_tx.sv
// Collects messages from N_CH show-ahead slave channels and serialises each as
// SYNC, ch, LEN, payload, CSUM toward the host link byte port.
module msg_uplink_tx
    import msg_uplink_tx_pkg::*;
#(
    parameter int         N_CH      = N_CH_DEFAULT,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              sys_clk,
    input  logic              n_rst,
    input  logic [N_CH-1:0]   have_msg_bus,
    input  logic [8*N_CH-1:0] len_bus,
    input  logic [8*N_CH-1:0] slave_data_bus,
    output logic [N_CH-1:0]   rdreq_bus,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              err_underrun
);

    localparam int IW = idx_w(N_CH);

    logic [7:0]      len_a  [N_CH];
    logic [7:0]      data_a [N_CH];
    logic [N_CH-1:0] elig;

    for (genvar i = 0; i < N_CH; i++) begin : g_slice
        assign len_a[i]  = len_bus[8*i +: 8];
        assign data_a[i] = slave_data_bus[8*i +: 8];
        assign elig[i]   = have_msg_bus[i] && (len_bus[8*i +: 8] != 8'd0);
    end

    state_t          state;
    logic [IW-1:0]   ch;
    logic [IW-1:0]   ptr;
    logic [N_CH-1:0] ch_oh;
    logic [7:0]      remaining;
    logic [7:0]      csum;

    logic [N_CH-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;

    msg_uplink_tx_rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req (elig),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    logic       accept;
    logic       ch_has;
    logic [7:0] ch_byte;
    logic [7:0] pl_byte;

    assign accept  = tx_valid && tx_ready;
    assign ch_has  = have_msg_bus[ch];
    assign ch_byte = 8'(ch);
    // An emptied channel is padded with zeros so the committed LEN still holds.
    assign pl_byte = ch_has ? data_a[ch] : 8'h00;

    // Pop coincides with the capture edge; PL_LOAD never overlaps a pending byte.
    assign rdreq_bus = (state == PL_LOAD && ch_has) ? ch_oh : '0;

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            ch           <= '0;
            ch_oh        <= '0;
            ptr          <= '0;
            remaining    <= '0;
            csum         <= '0;
            tx_data      <= '0;
            tx_valid     <= 1'b0;
            busy         <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|elig) begin
                    state <= SEL;
                    busy  <= 1'b1;
                end
                SEL: if (gnt_any) begin
                    ch        <= gnt_idx;
                    ch_oh     <= gnt;
                    remaining <= len_a[gnt_idx];
                    csum      <= '0;
                    ptr       <= (gnt_idx == IW'(N_CH-1)) ? '0 : gnt_idx + 1'b1;
                    tx_data   <= SYNC_BYTE;
                    tx_valid  <= 1'b1;
                    state     <= HDR_SYNC;
                end else begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                HDR_SYNC: if (accept) begin
                    tx_data <= ch_byte;
                    csum    <= csum + ch_byte;
                    state   <= HDR_CH;
                end
                HDR_CH: if (accept) begin
                    tx_data <= remaining;
                    csum    <= csum + remaining;
                    state   <= HDR_LEN;
                end
                HDR_LEN: if (accept) begin
                    tx_valid <= 1'b0;
                    state    <= PL_LOAD;
                end
                PL_LOAD: begin
                    tx_data  <= pl_byte;
                    csum     <= csum + pl_byte;
                    tx_valid <= 1'b1;
                    if (!ch_has) err_underrun <= 1'b1;
                    state    <= PL_SEND;
                end
                PL_SEND: if (accept) begin
                    remaining <= remaining - 8'd1;
                    if (remaining == 8'd1) begin
                        tx_data <= csum;
                        state   <= CSUM;
                    end else begin
                        tx_valid <= 1'b0;
                        state    <= PL_LOAD;
                    end
                end
                CSUM: if (accept) begin
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msg_uplink_tx.sv
// Directed bench for msg_uplink_tx: show-ahead channel models, byte capture, frame checks.
module tb_msg_uplink_tx;

    localparam int N = 5;

    logic           sys_clk = 1'b0;
    logic           n_rst;
    logic [N-1:0]   have_msg_bus;
    logic [8*N-1:0] len_bus;
    logic [8*N-1:0] slave_data_bus;
    logic [N-1:0]   rdreq_bus;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic           busy;
    logic           err_underrun;

    always #5 sys_clk = ~sys_clk;

    msg_uplink_tx #(.N_CH(N), .SYNC_BYTE(8'hAA)) dut (
        .sys_clk        (sys_clk),
        .n_rst          (n_rst),
        .have_msg_bus   (have_msg_bus),
        .len_bus        (len_bus),
        .slave_data_bus (slave_data_bus),
        .rdreq_bus      (rdreq_bus),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .busy           (busy),
        .err_underrun   (err_underrun)
    );

    logic [7:0] mem [N][512];
    int         wr [N];
    int         rd [N];
    int         ovr [N];
    int         rdcnt [N];
    logic [N-1:0] hm_force;
    logic [7:0] rx [$];
    logic [7:0] exp_q [$];
    int         tests, fails, stab_err;
    logic       prev_stall;
    logic [7:0] prev_data;

    // Show-ahead FIFO model per channel; len may be overridden to fake stale counts.
    always_comb begin
        int cnt;
        have_msg_bus   = '0;
        len_bus        = '0;
        slave_data_bus = '0;
        cnt            = 0;
        for (int i = 0; i < N; i++) begin
            cnt = wr[i] - rd[i];
            have_msg_bus[i] = (cnt > 0) || hm_force[i];
            len_bus[8*i +: 8] = (ovr[i] != 0) ? 8'(ovr[i]) : ((cnt > 255) ? 8'd255 : 8'(cnt));
            slave_data_bus[8*i +: 8] = (cnt > 0) ? mem[i][rd[i] % 512] : 8'h00;
        end
    end

    always @(posedge sys_clk)
        for (int i = 0; i < N; i++)
            if (rdreq_bus[i]) rd[i] <= rd[i] + 1;

    always @(negedge sys_clk) begin
        if (n_rst) begin
            if (prev_stall && (!tx_valid || tx_data !== prev_data)) stab_err++;
            if (rdreq_bus != '0 && tx_valid) stab_err++;
            for (int i = 0; i < N; i++)
                if (rdreq_bus[i]) begin
                    rdcnt[i]++;
                    if (wr[i] == rd[i]) stab_err++;
                end
            if (tx_valid && tx_ready) rx.push_back(tx_data);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic chk(input string tag, input int obs, input int expv);
        tests++;
        if (obs !== expv) begin
            fails++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic push(input int c, input logic [7:0] b);
        mem[c][wr[c] % 512] = b;
        wr[c]++;
    endtask

    // Expected frame from the channel model; bytes past the FIFO end read as zero pad.
    task automatic build(input int c, input int len, input int off);
        int sum;
        int idx;
        logic [7:0] b;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'(c));
        exp_q.push_back(8'(len));
        sum = c + len;
        for (int k = 0; k < len; k++) begin
            idx = rd[c] + off + k;
            b = (idx < wr[c]) ? mem[c][idx % 512] : 8'h00;
            exp_q.push_back(b);
            sum += int'(b);
        end
        exp_q.push_back(8'(sum));
    endtask

    task automatic wait_bytes(input string tag, input int n);
        int cyc = 0;
        while (rx.size() < n && cyc < 4000) begin
            tick(1);
            cyc++;
        end
        if (rx.size() < n) chk({tag, " timeout"}, rx.size(), n);
    endtask

    task automatic wait_rx(input string tag);
        wait_bytes(tag, exp_q.size());
        tick(3);
        chk({tag, " nbytes"}, rx.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++)
            chk($sformatf("%s byte%0d", tag, i), rx[i], exp_q[i]);
        chk({tag, " busy_after"}, busy, 0);
        rx.delete();
        exp_q.delete();
    endtask

    initial begin
        int base;
        int rem;
        tests = 0; fails = 0; stab_err = 0;
        hm_force = '0;
        tx_ready = 1'b1;
        n_rst    = 1'b0;
        tick(2);
        chk("rst tx_valid", tx_valid, 0);
        chk("rst tx_data", tx_data, 0);
        chk("rst busy", busy, 0);
        chk("rst rdreq", rdreq_bus, 0);
        chk("rst err", err_underrun, 0);
        n_rst = 1'b1;
        tick(2);

        // 1: ch4 len 3 -> AA 04 03 11 22 33 6D
        base = rdcnt[4];
        push(4, 8'h11); push(4, 8'h22); push(4, 8'h33);
        build(4, 3, 0);
        chk("t1 model csum", exp_q[6], 8'h6D);
        tick(3);
        chk("t1 busy", busy, 1);
        wait_rx("t1");
        chk("t1 rdreq", rdcnt[4] - base, 3);

        // 2: same frame, transmitter stalls on the second payload byte
        base = rdcnt[4];
        push(4, 8'h11); push(4, 8'h22); push(4, 8'h33);
        build(4, 3, 0);
        wait_bytes("t2 pre", 4);
        tx_ready = 1'b0;
        tick(5);
        chk("t2 hold data", tx_data, 8'h22);
        chk("t2 hold valid", tx_valid, 1);
        chk("t2 stall rdreq", rdcnt[4] - base, 2);
        tx_ready = 1'b1;
        wait_rx("t2");
        chk("t2 rdreq", rdcnt[4] - base, 3);

        // 3: ch1 and ch3 continuously pending with len 1 alternate
        ovr[1] = 1; ovr[3] = 1;
        push(1, 8'hA1); push(1, 8'hB1);
        push(3, 8'hA3); push(3, 8'hB3);
        build(1, 1, 0); build(3, 1, 0); build(1, 1, 1); build(3, 1, 1);
        wait_rx("t3");
        ovr[1] = 0; ovr[3] = 0;
        // pointer would favour ch4 here; reset must return it to ch0
        n_rst = 1'b0;
        push(4, 8'hC4); push(0, 8'hC0);
        build(0, 1, 0); build(4, 1, 0);
        tick(2);
        n_rst = 1'b1;
        wait_rx("t3 rst");

        // 4: ch2 commits LEN 4 but only two bytes exist
        chk("t4 err before", err_underrun, 0);
        base = rdcnt[2];
        ovr[2] = 4;
        push(2, 8'h5A); push(2, 8'h3C);
        build(2, 4, 0);
        chk("t4 model csum", exp_q[7], 8'h9C);
        wait_rx("t4");
        ovr[2] = 0;
        chk("t4 err", err_underrun, 1);
        chk("t4 rdreq", rdcnt[2] - base, 2);

        // 5: len 0 never starts a frame; reset mid-payload aborts
        base = rdcnt[0];
        hm_force[0] = 1'b1;
        tick(20);
        chk("t5 len0 busy", busy, 0);
        chk("t5 len0 bytes", rx.size(), 0);
        chk("t5 len0 rdreq", rdcnt[0] - base, 0);
        hm_force[0] = 1'b0;
        for (int i = 1; i <= 6; i++) push(3, 8'(i));
        wait_bytes("t5 pre", 5);
        n_rst = 1'b0;
        #1;
        chk("t5 rst valid", tx_valid, 0);
        chk("t5 rst data", tx_data, 0);
        chk("t5 rst busy", busy, 0);
        chk("t5 rst rdreq", rdreq_bus, 0);
        chk("t5 rst err", err_underrun, 0);
        rx.delete();
        rem = wr[3] - rd[3];
        build(3, rem, 0);
        tick(2);
        n_rst = 1'b1;
        wait_rx("t5 resume");

        // 6: maximum length frame, checksum wraps
        for (int i = 0; i < 255; i++) push(1, 8'((i * 37 + 11) & 255));
        build(1, 255, 0);
        chk("t6 model len", exp_q[2], 8'hFF);
        wait_rx("t6");

        chk("stability", stab_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global timeout: tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

endmodule
